mem_channel_router: RTL
=======================

MEM_CHANNEL_ROUTER -- requirements
Module: mem_channel_router

Interface
REQ-001 SHALL have parameter NUM_VIRT, default 2, number of application-side (virtual) memory ports.
REQ-002 SHALL have parameter NUM_PHY, default 2, number of physical DRAM channels; power of two, 1..4.
REQ-003 SHALL have parameter CH_BIT, default 6, lowest address bit of the channel-select field.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16, read-tracking FIFO depth per physical channel and per virtual port; power of two.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  user clock.
REQ-006 SHALL have: rst  input  1  synchronous active-high reset.
REQ-007 SHALL have: vir_mem_reqs  input  MemReq x NUM_VIRT  application requests (valid, isWrite, addr, data).
REQ-008 SHALL have: vir_mem_req_grants  output  1 x NUM_VIRT  request accepted this cycle.
REQ-009 SHALL have: vir_mem_resps  output  MemResp x NUM_VIRT  read data to application.
REQ-010 SHALL have: vir_mem_resp_grants  input  1 x NUM_VIRT  application consumes response this cycle.
REQ-011 SHALL have: phy_mem_reqs  output  MemReq x NUM_PHY  requests to DRAM channels.
REQ-012 SHALL have: phy_mem_req_grants  input  1 x NUM_PHY  channel accepted request.
REQ-013 SHALL have: phy_mem_resps  input  MemResp x NUM_PHY  in-order read data per channel.
REQ-014 SHALL have: phy_mem_resp_grants  output  1 x NUM_PHY  router consumes channel response.

Function
REQ-015 Target channel SHALL be addr[CH_BIT +: log2(NUM_PHY)] (channel 0 when NUM_PHY=1); addr forwarded unmodified.
REQ-016 Each channel SHALL own one output register slot; slot empty, or full and phy grant this cycle -> slot may load.
REQ-017 Per channel, SHALL arbitrate round-robin among valid virtual ports targeting it; pointer advances to winner+1 only on load.
REQ-018 Virtual grant SHALL assert in the cycle the request loads a slot; request->phy valid latency exactly 1 cycle; ungranted requests held unchanged by app.
REQ-019 A read SHALL only win if target channel FIFO and own virtual-port FIFO are both not full; writes need no FIFO space.
REQ-020 On read load, SHALL push virtual id into channel FIFO and channel id into virtual-port FIFO in the same cycle.
REQ-021 Writes SHALL produce no response and no FIFO entry.
REQ-022 Channel c response SHALL be presented to port v only when c FIFO head = v and v FIFO head = c; otherwise held (phy_mem_resp_grants[c]=0).
REQ-023 When presented: vir_mem_resps[v] = phy_mem_resps[c] combinationally; phy_mem_resp_grants[c] = vir_mem_resp_grants[v]; both FIFOs pop on that grant.
REQ-024 Responses per virtual port SHALL return in issue order across channels; no reordering permitted.
REQ-025 Phy valid with empty channel FIFO SHALL be ignored (no grant) and set a sticky internal error flag until reset.
REQ-026 Simultaneous push and pop on one FIFO SHALL keep occupancy; full FIFO with pop same cycle still blocks new push that cycle.
REQ-027 NUM_PHY=1, NUM_VIRT=1 SHALL degenerate to a 1-cycle registered pass-through with ordering FIFO.

Reset
REQ-028 During rst: all phy_mem_reqs valid=0, all vir_mem_req_grants=0, all vir_mem_resps valid=0, all phy_mem_resp_grants=0.
REQ-029 Reset SHALL empty all slots and FIFOs, clear error flag, set round-robin pointers to 0; in-flight traffic discarded.
REQ-030 First grant possible in cycle after rst deasserts.

Verification
REQ-031 Port 0 write addr 0x40 (ch1), port 1 write addr 0x00 (ch0) same cycle -> both granted same cycle, ch1/ch0 valid next cycle.
REQ-032 Both ports read addr 0x00 continuously, phy grant always 1 -> grants alternate 0,1,0,1 on ch0.
REQ-033 Port 0 reads 0x40 then 0x00; ch0 responds first -> ch0 held until ch1 response delivered; port 0 sees ch1 data then ch0 data.
REQ-034 16 reads to ch0 with no responses -> 17th read not granted; one response consumed -> 17th granted next cycle.
REQ-035 Reset asserted with 3 reads outstanding -> all outputs 0 next cycle; after release, stray phy response ignored, error flag set, no vir valid.
REQ-036 vir_mem_resp_grants[0]=0 for 5 cycles with response pending -> vir valid held stable, phy grant 0, data unchanged.

Source files
------------

// File: rtl/mem_channel_router.sv
`default_nettype none
// ============================================================================
// Module   : mem_channel_router
// Brief    : Routes virtual-port memory requests to address-selected DRAM
//            channels and returns read data to each port in issue order.
// Revision : 1.0 - initial release
// ============================================================================

package mem_router_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } MemReq;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] data;
    } MemResp;
endpackage

module mem_channel_router
    import mem_router_pkg::*;
#(
    parameter int NUM_VIRT        = 2,
    parameter int NUM_PHY         = 2,
    parameter int CH_BIT          = 6,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  MemReq               vir_mem_reqs        [NUM_VIRT],
    output logic [NUM_VIRT-1:0] vir_mem_req_grants,
    output MemResp              vir_mem_resps       [NUM_VIRT],
    input  logic [NUM_VIRT-1:0] vir_mem_resp_grants,
    output MemReq               phy_mem_reqs        [NUM_PHY],
    input  logic [NUM_PHY-1:0]  phy_mem_req_grants,
    input  MemResp              phy_mem_resps       [NUM_PHY],
    output logic [NUM_PHY-1:0]  phy_mem_resp_grants
);

    localparam int C_VID_W = (NUM_VIRT > 1) ? $clog2(NUM_VIRT) : 1;
    localparam int C_CH_W  = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
    localparam int C_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(MAX_OUTSTANDING);

    MemReq               slot_q [NUM_PHY];
    MemReq               slot_d [NUM_PHY];
    logic [C_VID_W-1:0]  rr_q   [NUM_PHY];
    logic [C_VID_W-1:0]  rr_d   [NUM_PHY];

    // Channel FIFOs remember which port owns each read; port FIFOs remember which channel
    logic [C_VID_W-1:0]  chf_mem_q [NUM_PHY][MAX_OUTSTANDING];
    logic [C_PTR_W-1:0]  chf_wp_q  [NUM_PHY];
    logic [C_PTR_W-1:0]  chf_rp_q  [NUM_PHY];
    logic [C_CNT_W-1:0]  chf_cnt_q [NUM_PHY];
    logic [C_CH_W-1:0]   vf_mem_q  [NUM_VIRT][MAX_OUTSTANDING];
    logic [C_PTR_W-1:0]  vf_wp_q   [NUM_VIRT];
    logic [C_PTR_W-1:0]  vf_rp_q   [NUM_VIRT];
    logic [C_CNT_W-1:0]  vf_cnt_q  [NUM_VIRT];

    logic [NUM_PHY-1:0]  chf_push;
    logic [NUM_PHY-1:0]  chf_pop;
    logic [C_VID_W-1:0]  chf_push_vid [NUM_PHY];
    logic [C_VID_W-1:0]  chf_head     [NUM_PHY];
    logic [NUM_VIRT-1:0] vf_push;
    logic [NUM_VIRT-1:0] vf_pop;
    logic [C_CH_W-1:0]   vf_push_ch   [NUM_VIRT];
    logic [C_CH_W-1:0]   vf_head      [NUM_VIRT];

    logic [C_CH_W-1:0]   tgt  [NUM_VIRT];
    logic [NUM_PHY-1:0]  elig [NUM_VIRT];
    logic [NUM_VIRT-1:0] req_gnt;
    logic                err_q;
    logic                err_d;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    for (genvar v = 0; v < NUM_VIRT; v++) begin : g_tgt
        if (NUM_PHY > 1) begin : g_sel
            assign tgt[v] = vir_mem_reqs[v].addr[CH_BIT +: C_CH_W];
        end else begin : g_single
            assign tgt[v] = '0;
        end
        assign vf_head[v] = vf_mem_q[v][vf_rp_q[v]];
    end

    for (genvar c = 0; c < NUM_PHY; c++) begin : g_chan
        assign chf_head[c] = chf_mem_q[c][chf_rp_q[c]];
        always_comb begin
            phy_mem_reqs[c] = slot_q[c];
            if (rst) begin
                phy_mem_reqs[c].valid = 1'b0;
            end
        end
    end

    // A full FIFO blocks a read even when it pops this cycle
    always_comb begin
        for (int v = 0; v < NUM_VIRT; v++) begin
            for (int c = 0; c < NUM_PHY; c++) begin
                elig[v][c] = vir_mem_reqs[v].valid && (int'(tgt[v]) == c) &&
                             (vir_mem_reqs[v].isWrite ||
                              (chf_cnt_q[c] != C_FULL && vf_cnt_q[v] != C_FULL));
            end
        end
    end

    always_comb begin
        logic               found;
        int                 idx;
        logic [C_VID_W-1:0] win;
        found    = 1'b0;
        idx      = 0;
        win      = '0;
        req_gnt  = '0;
        chf_push = '0;
        vf_push  = '0;
        for (int v = 0; v < NUM_VIRT; v++) begin
            vf_push_ch[v] = '0;
        end
        for (int c = 0; c < NUM_PHY; c++) begin
            slot_d[c]       = slot_q[c];
            rr_d[c]         = rr_q[c];
            chf_push_vid[c] = '0;
            if (phy_mem_req_grants[c]) begin
                slot_d[c].valid = 1'b0;
            end
            if (!slot_q[c].valid || phy_mem_req_grants[c]) begin
                found = 1'b0;
                win   = '0;
                for (int i = 0; i < NUM_VIRT; i++) begin
                    idx = int'(rr_q[c]) + i;
                    if (idx >= NUM_VIRT) begin
                        idx = idx - NUM_VIRT;
                    end
                    if (!found && elig[C_VID_W'(idx)][c]) begin
                        found = 1'b1;
                        win   = C_VID_W'(idx);
                    end
                end
                if (found) begin
                    slot_d[c]    = vir_mem_reqs[win];
                    rr_d[c]      = (int'(win) == NUM_VIRT - 1) ? '0 : win + 1'b1;
                    req_gnt[win] = 1'b1;
                    if (!vir_mem_reqs[win].isWrite) begin
                        chf_push[c]     = 1'b1;
                        chf_push_vid[c] = win;
                        vf_push[win]    = 1'b1;
                        vf_push_ch[win] = C_CH_W'(c);
                    end
                end
            end
        end
    end

    // A channel response is released only when both ordering FIFOs agree on the pairing
    always_comb begin
        phy_mem_resp_grants = '0;
        chf_pop             = '0;
        vf_pop              = '0;
        err_d               = err_q;
        for (int v = 0; v < NUM_VIRT; v++) begin
            vir_mem_resps[v] = '0;
        end
        if (!rst) begin
            for (int c = 0; c < NUM_PHY; c++) begin
                if (phy_mem_resps[c].valid) begin
                    if (chf_cnt_q[c] == '0) begin
                        err_d = 1'b1;
                    end else if (vf_cnt_q[chf_head[c]] != '0 &&
                                 int'(vf_head[chf_head[c]]) == c) begin
                        vir_mem_resps[chf_head[c]] = phy_mem_resps[c];
                        if (vir_mem_resp_grants[chf_head[c]]) begin
                            phy_mem_resp_grants[c] = 1'b1;
                            chf_pop[c]             = 1'b1;
                            vf_pop[chf_head[c]]    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign vir_mem_req_grants = rst ? '0 : req_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int c = 0; c < NUM_PHY; c++) begin
                slot_q[c]    <= '0;
                rr_q[c]      <= '0;
                chf_wp_q[c]  <= '0;
                chf_rp_q[c]  <= '0;
                chf_cnt_q[c] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int c = 0; c < NUM_PHY; c++) begin
                slot_q[c] <= slot_d[c];
                rr_q[c]   <= rr_d[c];
                if (chf_push[c]) begin
                    chf_mem_q[c][chf_wp_q[c]] <= chf_push_vid[c];
                    chf_wp_q[c]               <= ptr_inc(chf_wp_q[c]);
                end
                if (chf_pop[c]) begin
                    chf_rp_q[c] <= ptr_inc(chf_rp_q[c]);
                end
                chf_cnt_q[c] <= chf_cnt_q[c] + C_CNT_W'(chf_push[c]) - C_CNT_W'(chf_pop[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VIRT; v++) begin
                vf_wp_q[v]  <= '0;
                vf_rp_q[v]  <= '0;
                vf_cnt_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VIRT; v++) begin
                if (vf_push[v]) begin
                    vf_mem_q[v][vf_wp_q[v]] <= vf_push_ch[v];
                    vf_wp_q[v]              <= ptr_inc(vf_wp_q[v]);
                end
                if (vf_pop[v]) begin
                    vf_rp_q[v] <= ptr_inc(vf_rp_q[v]);
                end
                vf_cnt_q[v] <= vf_cnt_q[v] + C_CNT_W'(vf_push[v]) - C_CNT_W'(vf_pop[v]);
            end
        end
    end

endmodule

`default_nettype wire
